// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the 5-bit-opcode ALU: accept, read operands,
// pulse the opcode for one EXEC cycle, then write the ALU result back.
module alu_issue_ctrl #(
  parameter int          DATA_W  = 32,
  parameter int          NREGS   = 8,
  parameter int          REG_AW  = 3,
  parameter logic [4:0]  IDLE_OP = 5'b00010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_flag,
  output logic              done,
  output logic [REG_AW-1:0] done_rd,
  output logic [DATA_W-1:0] done_result,
  output logic              flag_q,
  output logic              illegal,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  typedef enum logic [2:0] {IDLE, OPND, EXEC, WB, ERR} state_t;

  typedef struct packed {
    logic [4:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic              imm_sel;
    logic [15:0]       imm;
  } instr_t;

  state_t                        state, state_nxt;
  instr_t                        iq;
  logic [NREGS-1:0][DATA_W-1:0]  regs;
  logic [DATA_W-1:0]             opa, opb, imm_ext;
  logic                          unused_bits;

  assign unused_bits = instr[16];

  function automatic logic op_legal(input logic [4:0] op);
    logic ok;
    ok = op[4];
    case (op)
      5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9: ok = 1'b1;
      default: ;
    endcase
    return ok;
  endfunction

  // reg[0] is hardwired to zero on every read path
  always_comb begin
    opa      = (iq.ra == '0)    ? '0 : regs[iq.ra];
    opb      = (iq.rb == '0)    ? '0 : regs[iq.rb];
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    imm_ext  = {{(DATA_W-16){iq.imm[15]}}, iq.imm};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = op_legal(instr[31:27]) ? OPND : ERR;
      OPND:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Opcode toggles IDLE_OP -> op -> IDLE_OP so the ALU sees a change per instruction
  assign instr_ready = (state == IDLE);
  assign alu_opcode  = (state == EXEC) ? iq.op : IDLE_OP;
  assign done        = (state == WB);
  assign illegal     = (state == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      iq          <= '0;
      regs        <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      done_rd     <= '0;
      done_result <= '0;
      flag_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (instr_valid) begin
          iq.op      <= instr[31:27];
          iq.rd      <= instr[24 +: REG_AW];
          iq.ra      <= instr[21 +: REG_AW];
          iq.rb      <= instr[18 +: REG_AW];
          iq.imm_sel <= instr[17];
          iq.imm     <= instr[15:0];
        end
        OPND: begin
          alu_a <= opa;
          alu_b <= iq.imm_sel ? imm_ext : opb;
        end
        // Result captured on the EXEC->WB edge so it is visible alongside done
        EXEC: begin
          if (iq.rd != '0) regs[iq.rd] <= alu_out;
          done_result <= alu_out;
          done_rd     <= iq.rd;
          flag_q      <= alu_flag;
        end
        default: ;
      endcase
    end
  end
endmodule
